// File: rtl/timer_pkg.sv
// Shared definitions for the timing/peripheral cluster: state encoding and
// timer mode constants used by down_timer and its neighbours.
package timer_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN
  } timer_state_t;

endpackage

// File: rtl/down_timer.sv
// Programmable down-counting timer: reload register, qualified-tick countdown
// and a registered one-cycle terminal-count pulse, one-shot or periodic.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | not counting; count holds; start with reload=0 pulses tc_o
// S_RUN  | decrement on tick_i; at count=1 emit tc_o, reload or stop
module down_timer
  import timer_pkg::*;
#(
  parameter int BW = 4
) (
  input  logic          clk_i,
  input  logic          rstSync_i,
  input  logic          load_i,
  input  logic [BW-1:0] loadVal_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          tick_i,
  input  logic          mode_i,
  output logic [BW-1:0] count_o,
  output logic          busy_o,
  output logic          tc_o
);

  timer_state_t  state, state_nxt;
  logic [BW-1:0] reload;
  logic [BW-1:0] count, count_nxt;
  logic          tc_nxt;

  always_ff @(posedge clk_i) begin
    if (rstSync_i) begin
      state  <= S_IDLE;
      reload <= '0;
      count  <= '0;
      tc_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      tc_o  <= tc_nxt;
      // Reload is updated independently of the stop/start/tick chain.
      if (load_i) reload <= loadVal_i;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (stop_i) begin
      state_nxt = S_IDLE;
    end else if (start_i) begin
      // A zero reload is an immediate expiry: one pulse, no RUN phase.
      if (reload != '0) begin
        count_nxt = reload;
        state_nxt = S_RUN;
      end else begin
        count_nxt = '0;
        state_nxt = S_IDLE;
        tc_nxt    = 1'b1;
      end
    end else if (state == S_RUN && tick_i) begin
      if (count <= BW'(1)) begin
        tc_nxt = 1'b1;
        if (mode_i == MODE_PERIODIC && reload != '0) begin
          count_nxt = reload;
        end else begin
          count_nxt = '0;
          state_nxt = S_IDLE;
        end
      end else begin
        count_nxt = count - BW'(1);
      end
    end
  end

  assign count_o = count;
  assign busy_o  = (state == S_RUN);

endmodule

// File: doc/down_timer.md
# down_timer

Programmable down-counting timer: the decrementing counterpart to the team's free-running up-counter. Loads a reload value, counts down on qualified ticks, and emits a one-cycle terminal-count pulse, in one-shot or periodic mode. Sits beside the counter in the timing/peripheral cluster and drives event and interrupt logic from `tc_o`.

## Interface

Parameters:
- `BW`, 4, counter and reload width in bits.

Ports:
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rstSync_i`  in  1  reset, synchronous and active-high.
- `load_i`  in  1  write `loadVal_i` into the reload register.
- `loadVal_i`  in  BW  reload value N.
- `start_i`  in  1  copy reload into count and enter RUN.
- `stop_i`  in  1  halt counting and return to IDLE.
- `tick_i`  in  1  count-enable qualifier; decrement only when high.
- `mode_i`  in  1  0 = one-shot, 1 = periodic; sampled at terminal count.
- `count_o`  out  BW  current count.
- `busy_o`  out  1  high while in RUN.
- `tc_o`  out  1  terminal-count pulse, exactly one cycle wide.

## Operation

- Registers: `reload` (BW), `count` (BW), `state` ∈ {IDLE, RUN}, and `tc_o` (registered).
- Reset (`rstSync_i` = 1 at an edge): `count` = 0, `reload` = 0, `state` = IDLE, `tc_o` = 0, `busy_o` = 0.
- `load_i` updates `reload` only and never touches a running `count`. In periodic mode, the next reload uses the new value.
- Priority per edge: reset > stop > start > tick. `load_i` is independent of this chain and still applies when stop or start is asserted in the same cycle.
- IDLE:
  - `count` holds.
  - `start_i` with `reload` ≠ 0: `count` ← `reload`, go to RUN.
  - `start_i` with `reload` = 0: stay in IDLE, `count` ← 0, `tc_o` pulses once.
  - `tick_i` is ignored.
- RUN, `tick_i` = 1, `count` > 1: `count` ← `count` − 1.
- RUN, `tick_i` = 1, `count` = 1 (terminal):
  - `tc_o` ← 1 for one cycle.
  - Periodic: `count` ← `reload`, stay in RUN. If `reload` = 0 here, `count` ← 0 and go to IDLE.
  - One-shot: `count` ← 0, go to IDLE.
- RUN, `tick_i` = 0: `count` holds.
- `start_i` in RUN restarts: `count` ← `reload`, and a simultaneous tick is discarded.
- `stop_i` in RUN: go to IDLE, `count` holds the stopped value, no `tc_o`.
- `count` never underflows. RUN with `count` = 0 is unreachable.
- `busy_o` = (`state` == RUN), combinational from the state register.

## Timing

- Start latency: `start_i` sampled at edge k → `count_o` = N and `busy_o` = 1 after edge k.
- Period: with `tick_i` held high, `tc_o` asserts N cycles after the start edge. In periodic mode it then repeats every N cycles.
- With sparse ticks, the period is N qualified ticks.
- `tc_o` rises on the same edge at which `count` becomes 0 (one-shot) or reloads (periodic), and falls on the next edge.
- Back-to-back terminal counts (N = 1, periodic, continuous tick) make `tc_o` high every cycle. This is legal, and each cycle counts as one event.
- Reset mid-RUN: at the next edge all registers take their reset values; a pending `tc_o` is cleared.

## Structure

- Shared package/header `timer_pkg`:
  - state encoding localparams `ST_IDLE` = 1'b0, `ST_RUN` = 1'b1;
  - mode constants `MODE_ONESHOT` = 0, `MODE_PERIODIC` = 1.
- One natural sub-module: `tick_gen`, a prescaler producing `tick_i` from `clk_i` with a programmable divide ratio.
  - It is instantiated by the parent, not inside `down_timer`.
  - `down_timer` itself is a single flat module: FSM plus datapath.

## Test plan

- Reset, then `load_i` with 5, `start_i`, one-shot, tick held high → `count_o` 5,4,3,2,1,0; `tc_o` high only in the cycle `count_o` = 0; `busy_o` falls on the same edge.
- Periodic, N = 3, continuous tick for 10 cycles → `tc_o` at cycles 3, 6, 9 after start; `count_o` sequence 3,2,1,3,2,1,….
- Tick high every 2nd cycle, N = 2, one-shot → `tc_o` after 2 ticks (4 cycles); `count_o` holds during tick-low cycles.
- Mid-run `stop_i` at `count_o` = 2 → IDLE, `count_o` stays 2, no `tc_o`. Then `start_i` + `stop_i` in the same cycle → stop wins, still IDLE.
- Periodic N = 4: `load_i` 2 mid-run → current period completes at 4, next periods are 2. `start_i` with `reload` = 0 → single `tc_o`, `busy_o` stays 0.
- `rstSync_i` asserted in RUN with `count_o` = 1 and tick high → next edge: `count_o` 0, `tc_o` 0, `busy_o` 0, and `reload` reads 0 on the next start.
